readout_sched: RTL

READOUT_SCHED -- requirements
Module: readout_sched

---
 rtl/readout_pkg.sv | 30 +++
 rtl/l1a_req_fifo.sv | 53 +++++
 rtl/readout_sched.sv | 136 +++++++++++++
 3 files changed

// File: rtl/readout_pkg.sv
// Shared types for the L1A readout scheduler: FSM encoding, queue entry, counter widths.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package readout_pkg;

  localparam int ADR_W   = 4;
  localparam int NUM_W   = 6;
  localparam int ENTRY_W = ADR_W + NUM_W;
  localparam int DROP_W  = 8;
  localparam int OCC_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_RELEASE = 3'd3,
    ST_GAP     = 3'd4
  } state_t;

  typedef struct packed {
    logic [ADR_W-1:0] adr;
    logic [NUM_W-1:0] num;
  } entry_t;

  // Bitwise 2-of-3 majority over three copies of the state register.
  function automatic state_t vote3(input state_t a, input state_t b, input state_t c);
    return state_t'((a & b) | (a & c) | (b & c));
  endfunction

endpackage

// File: rtl/l1a_req_fifo.sv
// FIFO of pending L1A readout requests with occupancy and first-word-fall-through head.
// Latency: a push is visible in occ and head on the cycle after it is sampled.
// Backpressure: push is ignored when full unless a pop happens in the same cycle.
module l1a_req_fifo
  import readout_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             push,
  input  entry_t           push_dat,
  input  logic             pop,
  output logic             full,
  output logic [OCC_W-1:0] occ,
  output entry_t           head
);

  localparam int AW = $clog2(DEPTH);
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  entry_t      mem [DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic [AW:0] cnt;
  logic        rd;
  logic        wr;

  assign cnt  = wptr - rptr;
  assign full = (cnt == FULL_CNT);
  assign occ  = OCC_W'(cnt);
  assign head = mem[rptr[AW-1:0]];
  assign rd   = pop && (cnt != '0);
  assign wr   = push && (!full || rd);

  // Pointer update; low bits index storage so both wrap modulo DEPTH.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge CLK) begin
    if (wr) mem[wptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/readout_sched.sv
// Schedules SCA block readouts from queued L1A requests and releases blocks when done.
// Latency: push into empty queue -> RD_START 2 cycles later; RD_DONE -> BLK_FREE next cycle.
// Backpressure: pushes beyond DEPTH are dropped and counted (saturating), never stalled.
module readout_sched
  import readout_pkg::*;
#(
  parameter int TMR     = 0,
  parameter int DEPTH   = 4,
  parameter int TMO_CYC = 1023
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              L1A_PUSH,
  input  logic [ADR_W-1:0]  L1A_ADR,
  input  logic [NUM_W-1:0]  L1A_NUM,
  output logic              L1A_FULL,
  output logic [OCC_W-1:0]  OCC,
  output logic              RD_START,
  output logic [ADR_W-1:0]  RD_ADR,
  output logic [NUM_W-1:0]  RD_NUM,
  input  logic              RD_DONE,
  output logic              RD_BUSY,
  output logic              BLK_FREE,
  output logic [ADR_W-1:0]  BLK_FREE_ADR,
  output logic              TMO_ERR,
  output logic [DROP_W-1:0] DROP_CNT
);

  localparam int NCOPY = (TMR != 0) ? 3 : 1;
  localparam int WDW   = $clog2(TMO_CYC + 1);
  // Watchdog value on the TMO_CYC-th WAIT cycle (counter starts at 0 on entry).
  localparam logic [WDW-1:0] WD_LAST = WDW'(TMO_CYC - 1);

  state_t           st_q [NCOPY];
  state_t           st;
  logic [WDW-1:0]   wdog;
  logic             pop;
  logic             push_ok;
  logic             fifo_full;
  logic [OCC_W-1:0] fifo_occ;
  entry_t           push_dat;
  entry_t           head;

  if (TMR != 0) begin : g_tmr
    assign st = vote3(st_q[0], st_q[1], st_q[2]);
  end else begin : g_simplex
    assign st = st_q[0];
  end

  assign pop      = (st == ST_START);
  assign push_ok  = L1A_PUSH && (!fifo_full || pop);
  assign push_dat = '{adr: L1A_ADR, num: L1A_NUM};
  assign L1A_FULL = fifo_full;
  assign OCC      = fifo_occ;

  l1a_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .push     (push_ok),
    .push_dat (push_dat),
    .pop      (pop),
    .full     (fifo_full),
    .occ      (fifo_occ),
    .head     (head)
  );

  // Count pushes refused by a full queue, holding at all-ones.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      DROP_CNT <= '0;
    end else if (L1A_PUSH && !push_ok && (DROP_CNT != '1)) begin
      DROP_CNT <= DROP_CNT + 1'b1;
    end
  end

  // Readout FSM with registered outputs; every copy of the state is rewritten each cycle.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      st_q         <= '{default: ST_IDLE};
      RD_START     <= 1'b0;
      RD_BUSY      <= 1'b0;
      BLK_FREE     <= 1'b0;
      RD_ADR       <= '0;
      RD_NUM       <= '0;
      BLK_FREE_ADR <= '0;
      TMO_ERR      <= 1'b0;
      wdog         <= '0;
    end else begin
      st_q     <= '{default: st};
      RD_START <= 1'b0;
      BLK_FREE <= 1'b0;
      case (st)
        ST_IDLE: begin
          if (fifo_occ != '0) begin
            st_q     <= '{default: ST_START};
            RD_START <= 1'b1;
            RD_BUSY  <= 1'b1;
            RD_ADR   <= head.adr;
            RD_NUM   <= head.num;
          end
        end
        ST_START: begin
          st_q <= '{default: ST_WAIT};
          wdog <= '0;
        end
        ST_WAIT: begin
          // A completion arriving on the expiry cycle wins over the timeout.
          if (RD_DONE) begin
            st_q         <= '{default: ST_RELEASE};
            BLK_FREE     <= 1'b1;
            BLK_FREE_ADR <= RD_ADR;
          end else if (wdog == WD_LAST) begin
            st_q         <= '{default: ST_RELEASE};
            BLK_FREE     <= 1'b1;
            BLK_FREE_ADR <= RD_ADR;
            TMO_ERR      <= 1'b1;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        ST_RELEASE: begin
          st_q    <= '{default: ST_GAP};
          RD_BUSY <= 1'b0;
        end
        ST_GAP: begin
          st_q <= '{default: ST_IDLE};
        end
        default: begin
          st_q    <= '{default: ST_IDLE};
          RD_BUSY <= 1'b0;
        end
      endcase
    end
  end

endmodule
